// File: rtl/fb_pkg.sv
// fb_pkg: shared state encoding and default geometry/timing for the frame-buffer arbiter.
package fb_pkg;
  typedef enum logic [1:0] {READ, RD2WR, WRITE, WR2RD} fb_state_t;
  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int COORD_W_DEF = 10;
  localparam int RD_CYC_DEF  = 3;
  localparam int WR_CYC_DEF  = 3;
endpackage

// File: rtl/fb_access_timer.sv
// fb_access_timer: per-access cycle counter; last may be held to stretch the final cycle.
module fb_access_timer import fb_pkg::*; #(
  parameter int CYC = RD_CYC_DEF,
  parameter int CW  = $clog2(CYC)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic run_i,
  input  logic hold_i,
  output logic busy_o,
  output logic last_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign busy_o = cnt_q != '0;
  assign last_o = cnt_q == CW'(CYC - 1);
  always_comb cnt_d = !run_i ? '0 : last_o ? (hold_i ? cnt_q : '0) : cnt_q + 1'b1;
  always_ff @(posedge Clk) cnt_q <= Reset ? '0 : cnt_d;
endmodule

// File: rtl/fb_page_arbiter.sv
// fb_page_arbiter: time-shares one async SRAM between line prefetch (front page)
// and renderer writes (back page), flipping pages in vertical blank.
module fb_page_arbiter import fb_pkg::*; #(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int RD_CYC  = RD_CYC_DEF,
  parameter int WR_CYC  = WR_CYC_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               VGA_BLANK_N,
  input  logic               fifo_full,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [COORD_W-1:0] ReadX,
  output logic [COORD_W-1:0] ReadY,
  output logic [COORD_W-1:0] SaveX,
  output logic [COORD_W-1:0] SaveY,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               fifo_we,
  output logic               PauseVGA,
  output logic               flip_page,
  output logic               frame_done
);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] V_END  = COORD_W'(V_RES);
  fb_state_t state_q;
  logic [COORD_W-1:0] read_x_q, read_y_q, save_x_q, save_y_q;
  logic flip_q, frame_ready_q, exit_pend_q, frame_done_q;
  logic rd_act, rd_busy, rd_last, rd_push;
  logic wr_act, wr_busy, wr_last, wr_start, wr_done;
  logic exit_any, flip_cond;
  fb_access_timer #(.CYC(RD_CYC)) u_rd_timer (
    .Clk(Clk), .Reset(Reset), .run_i(rd_act), .hold_i(fifo_full),
    .busy_o(rd_busy), .last_o(rd_last)
  );
  fb_access_timer #(.CYC(WR_CYC)) u_wr_timer (
    .Clk(Clk), .Reset(Reset), .run_i(wr_act), .hold_i(1'b0),
    .busy_o(wr_busy), .last_o(wr_last)
  );
  assign rd_act    = state_q == READ || rd_busy;
  assign rd_push   = state_q == READ && rd_last && !fifo_full;
  assign exit_any  = DrawX == H_LAST || exit_pend_q;
  // a pending line exit or a finished frame blocks new writes
  assign wr_start  = state_q == WRITE && !wr_busy && pix_valid && !frame_ready_q && !exit_any;
  assign wr_act    = wr_start || wr_busy;
  assign wr_done   = wr_act && wr_last;
  assign flip_cond = frame_ready_q && !VGA_BLANK_N && DrawY >= V_END;
  // an access cut short by reset never reports completion
  assign fifo_we    = rd_push && !Reset;
  assign pix_ready  = wr_done && !Reset;
  assign PauseVGA   = state_q == READ || state_q == WR2RD;
  assign SRAM_OE_N  = !rd_act;
  assign SRAM_CE_N  = !(rd_act || wr_act);
  assign SRAM_UB_N  = SRAM_CE_N;
  assign SRAM_LB_N  = SRAM_CE_N;
  assign SRAM_WE_N  = !(wr_act && !wr_last);
  assign ReadX      = read_x_q;
  assign ReadY      = read_y_q;
  assign SaveX      = save_x_q;
  assign SaveY      = save_y_q;
  assign flip_page  = flip_q;
  assign frame_done = frame_done_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= READ;
      read_x_q      <= '0;
      read_y_q      <= '0;
      save_x_q      <= '0;
      save_y_q      <= '0;
      flip_q        <= 1'b0;
      frame_ready_q <= 1'b0;
      exit_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        READ: if (rd_push) begin
          read_x_q <= read_x_q + 1'b1;
          if (read_x_q == H_LAST) state_q <= RD2WR;
        end
        RD2WR: begin
          read_x_q <= '0;
          read_y_q <= read_y_q == V_LAST ? '0 : read_y_q + 1'b1;
          state_q  <= WRITE;
        end
        WRITE: begin
          if (wr_done) begin
            if (save_x_q != H_LAST) save_x_q <= save_x_q + 1'b1;
            else if (save_y_q == V_LAST) frame_ready_q <= 1'b1;
            else begin
              save_x_q <= '0;
              save_y_q <= save_y_q + 1'b1;
            end
          end
          if (exit_any && (!wr_act || wr_last)) state_q <= WR2RD;
          else if (exit_any) exit_pend_q <= 1'b1;
        end
        WR2RD: begin
          exit_pend_q <= 1'b0;
          state_q     <= READ;
        end
        default: state_q <= READ;
      endcase
      if (flip_cond) begin
        flip_q        <= ~flip_q;
        save_x_q      <= '0;
        save_y_q      <= '0;
        frame_ready_q <= 1'b0;
        frame_done_q  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fb_page_arbiter.sv
// tb_fb_page_arbiter: directed scenarios on an 8x4 frame with 3-cycle SRAM accesses.
module tb_fb_page_arbiter;
  localparam int W = 10;
  logic Clk = 1'b0, Reset = 1'b1, VGA_BLANK_N = 1'b1, fifo_full = 1'b0, pix_valid = 1'b0;
  logic [W-1:0] DrawX = '0, DrawY = '0;
  logic pix_ready, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
  logic fifo_we, PauseVGA, flip_page, frame_done;
  logic [W-1:0] ReadX, ReadY, SaveX, SaveY;
  int vectors = 0, miscompares = 0;
  always #5 Clk = ~Clk;
  fb_page_arbiter #(.H_RES(8), .V_RES(4), .COORD_W(W), .RD_CYC(3), .WR_CYC(3)) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .VGA_BLANK_N(VGA_BLANK_N),
    .fifo_full(fifo_full), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ReadX(ReadX), .ReadY(ReadY), .SaveX(SaveX), .SaveY(SaveY),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .fifo_we(fifo_we),
    .PauseVGA(PauseVGA), .flip_page(flip_page), .frame_done(frame_done)
  );
  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 1'b0; #1;
    vectors++;
    if ({PauseVGA, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 6'b100100) begin
      miscompares++; $display("FAIL reset_strobes: got %b expected 100100", {PauseVGA, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
    end
    vectors++;
    if ({ReadX, ReadY, SaveX, SaveY} !== '0) begin
      miscompares++; $display("FAIL reset_coords: got %0d %0d %0d %0d expected 0 0 0 0", ReadX, ReadY, SaveX, SaveY);
    end
    vectors++;
    if ({flip_page, frame_done, fifo_we, pix_ready} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 0000", {flip_page, frame_done, fifo_we, pix_ready});
    end
    @(negedge Clk); #1;
    vectors++;
    if (fifo_we !== 1'b0) begin
      miscompares++; $display("FAIL reset_early_push: got %b expected 0", fifo_we);
    end
  endtask
  task automatic test_read_line();
    int pushes = 0;
    for (int c = 2; c <= 25; c++) begin
      @(negedge Clk); #1;
      if (fifo_we === 1'b1) pushes++;
      if (c <= 23) begin
        vectors++;
        if (fifo_we !== 1'(c % 3 == 2)) begin
          miscompares++; $display("FAIL read_push c=%0d: got %b expected %b", c, fifo_we, c % 3 == 2);
        end
        vectors++;
        if (ReadX !== W'(c / 3)) begin
          miscompares++; $display("FAIL read_x c=%0d: got %0d expected %0d", c, ReadX, c / 3);
        end
      end else if (c == 24) begin
        vectors++;
        if ({PauseVGA, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 4'b0111) begin
          miscompares++; $display("FAIL rd2wr_strobes: got %b expected 0111", {PauseVGA, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N});
        end
      end else begin
        vectors++;
        if ({ReadX, ReadY} !== {W'(0), W'(1)} || PauseVGA !== 1'b0 || SRAM_CE_N !== 1'b1) begin
          miscompares++; $display("FAIL write_entry: got x=%0d y=%0d pause=%b ce_n=%b expected 0 1 0 1", ReadX, ReadY, PauseVGA, SRAM_CE_N);
        end
      end
    end
    vectors++;
    if (pushes !== 8) begin
      miscompares++; $display("FAIL read_push_count: got %0d expected 8", pushes);
    end
  endtask
  task automatic test_write_row();
    for (int w = 0; w < 24; w++) begin
      @(negedge Clk); pix_valid = 1'b1; #1;
      vectors++;
      if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, pix_ready} !== {1'b0, 1'b1, 1'(w % 3 == 2), 1'(w % 3 == 2)}) begin
        miscompares++; $display("FAIL write_strobes w=%0d: got %b expected %b", w, {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, pix_ready}, {1'b0, 1'b1, 1'(w % 3 == 2), 1'(w % 3 == 2)});
      end
      vectors++;
      if ({SaveX, SaveY} !== {W'(w / 3), W'(0)}) begin
        miscompares++; $display("FAIL write_coord w=%0d: got %0d,%0d expected %0d,0", w, SaveX, SaveY, w / 3);
      end
    end
    @(negedge Clk); pix_valid = 1'b0; #1;
    vectors++;
    if ({SaveX, SaveY} !== {W'(0), W'(1)} || SRAM_WE_N !== 1'b1 || PauseVGA !== 1'b0) begin
      miscompares++; $display("FAIL write_wrap: got %0d,%0d we_n=%b pause=%b expected 0,1 1 0", SaveX, SaveY, SRAM_WE_N, PauseVGA);
    end
  endtask
  task automatic test_exit_mid_access();
    @(negedge Clk); pix_valid = 1'b1; #1;
    vectors++;
    if (SRAM_WE_N !== 1'b0) begin
      miscompares++; $display("FAIL exit_start: got we_n=%b expected 0", SRAM_WE_N);
    end
    @(negedge Clk); pix_valid = 1'b0; DrawX = W'(7); #1;
    vectors++;
    if ({SRAM_WE_N, pix_ready, PauseVGA} !== 3'b000) begin
      miscompares++; $display("FAIL exit_req_cycle: got %b expected 000", {SRAM_WE_N, pix_ready, PauseVGA});
    end
    @(negedge Clk); DrawX = '0; #1;
    vectors++;
    if ({SRAM_WE_N, pix_ready, PauseVGA} !== 3'b110) begin
      miscompares++; $display("FAIL exit_completes: got %b expected 110", {SRAM_WE_N, pix_ready, PauseVGA});
    end
    @(negedge Clk); #1;
    vectors++;
    if ({PauseVGA, SRAM_CE_N, SRAM_WE_N, pix_ready} !== 4'b1110 || SaveX !== W'(1)) begin
      miscompares++; $display("FAIL wr2rd: got %b savex=%0d expected 1110 savex=1", {PauseVGA, SRAM_CE_N, SRAM_WE_N, pix_ready}, SaveX);
    end
    @(negedge Clk); #1;
    vectors++;
    if ({PauseVGA, SRAM_OE_N} !== 2'b10 || {ReadX, ReadY} !== {W'(0), W'(1)}) begin
      miscompares++; $display("FAIL back_to_read: got pause/oe_n=%b x=%0d y=%0d expected 10 0 1", {PauseVGA, SRAM_OE_N}, ReadX, ReadY);
    end
  endtask
  task automatic test_fifo_full();
    int pushes = 0;
    bit done = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge Clk); fifo_full = c >= 11 && c <= 15; #1;
      vectors++;
      if (fifo_we !== 1'((c % 3 == 2 && c < 11) || c == 16)) begin
        miscompares++; $display("FAIL full_push c=%0d: got %b expected %b", c, fifo_we, (c % 3 == 2 && c < 11) || c == 16);
      end
      if (c >= 9) begin
        vectors++;
        if (ReadX !== W'(c == 17 ? 4 : 3)) begin
          miscompares++; $display("FAIL full_hold_x c=%0d: got %0d expected %0d", c, ReadX, c == 17 ? 4 : 3);
        end
      end
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clk); #1;
      if (fifo_we === 1'b1) pushes++;
      if (PauseVGA === 1'b0) done = 1'b1;
    end
    vectors++;
    if (!done || pushes !== 4) begin
      miscompares++; $display("FAIL full_line_end: got done=%b pushes=%0d expected 1 4", done, pushes);
    end
    @(negedge Clk); #1;
    vectors++;
    if ({ReadX, ReadY} !== {W'(0), W'(2)}) begin
      miscompares++; $display("FAIL full_next_line: got %0d,%0d expected 0,2", ReadX, ReadY);
    end
  endtask
  task automatic test_frame_flip();
    int n = 0;
    for (int i = 0; i < 100 && n < 22; i++) begin
      @(negedge Clk); pix_valid = 1'b1; #1;
      if (pix_ready === 1'b1) n++;
    end
    vectors++;
    if (n !== 22) begin
      miscompares++; $display("FAIL frame_pixels: got %0d expected 22", n);
    end
    @(negedge Clk); VGA_BLANK_N = 1'b0; DrawY = W'(4); #1;
    vectors++;
    if ({SaveX, SaveY} !== {W'(7), W'(3)} || SRAM_WE_N !== 1'b0) begin
      miscompares++; $display("FAIL last_pixel_start: got %0d,%0d we_n=%b expected 7,3 0", SaveX, SaveY, SRAM_WE_N);
    end
    @(negedge Clk); #1;
    @(negedge Clk); #1;
    vectors++;
    if ({pix_ready, flip_page, frame_done} !== 3'b100) begin
      miscompares++; $display("FAIL last_pixel_done: got %b expected 100", {pix_ready, flip_page, frame_done});
    end
    @(negedge Clk); #1;
    vectors++;
    if ({flip_page, frame_done, SRAM_CE_N, SRAM_WE_N} !== 4'b0011 || {SaveX, SaveY} !== {W'(7), W'(3)}) begin
      miscompares++; $display("FAIL flip_wait: got %b %0d,%0d expected 0011 7,3", {flip_page, frame_done, SRAM_CE_N, SRAM_WE_N}, SaveX, SaveY);
    end
    @(negedge Clk); pix_valid = 1'b0; #1;
    vectors++;
    if ({flip_page, frame_done} !== 2'b11 || {SaveX, SaveY} !== '0) begin
      miscompares++; $display("FAIL flip: got %b %0d,%0d expected 11 0,0", {flip_page, frame_done}, SaveX, SaveY);
    end
    @(negedge Clk); VGA_BLANK_N = 1'b1; DrawY = '0; #1;
    vectors++;
    if ({flip_page, frame_done} !== 2'b10) begin
      miscompares++; $display("FAIL flip_once: got %b expected 10", {flip_page, frame_done});
    end
  endtask
  task automatic test_reset_mid_write();
    @(negedge Clk); pix_valid = 1'b1; #1;
    vectors++;
    if (SRAM_WE_N !== 1'b0) begin
      miscompares++; $display("FAIL rst_write_start: got we_n=%b expected 0", SRAM_WE_N);
    end
    @(negedge Clk); #1;
    @(negedge Clk); Reset = 1'b1; #1;
    vectors++;
    if (pix_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_abort_ready: got %b expected 0", pix_ready);
    end
    @(negedge Clk); Reset = 1'b0; pix_valid = 1'b0; #1;
    vectors++;
    if ({SRAM_WE_N, pix_ready, flip_page, PauseVGA} !== 4'b1001 || SaveX !== '0) begin
      miscompares++; $display("FAIL rst_after: got %b savex=%0d expected 1001 0", {SRAM_WE_N, pix_ready, flip_page, PauseVGA}, SaveX);
    end
    repeat (3) begin
      @(negedge Clk); #1;
      vectors++;
      if (pix_ready !== 1'b0) begin
        miscompares++; $display("FAIL rst_no_late_ready: got %b expected 0", pix_ready);
      end
    end
  endtask
  initial begin
    test_reset();
    test_read_line();
    test_write_row();
    test_exit_mid_access();
    test_fifo_full();
    test_frame_flip();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fb_page_arbiter.md
Name: fb_page_arbiter

Overview:
Parametrised double-buffered frame-buffer arbiter that time-shares one asynchronous SRAM between a VGA line prefetcher and the pixel renderer. Each scanline it prefetches the next display line from the front page into the line FIFO, paced by FIFO back-pressure. It then services renderer pixel writes into the back page through a valid/ready handshake. It flips pages only during vertical blank, after a complete frame has been rendered. It sits between vga_controller, the line FIFO and the SRAM pins, replacing the fixed 640x480 controller.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
COORD_W, 10, width of all X/Y coordinates; must satisfy 2^COORD_W > max(H_RES, V_RES)
RD_CYC, 3, clocks per SRAM read access (>=2)
WR_CYC, 3, clocks per SRAM write access (>=2)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
DrawX  in  COORD_W  current VGA column
DrawY  in  COORD_W  current VGA row
VGA_BLANK_N  in  1  low during any blanking interval
fifo_full  in  1  line FIFO cannot accept a pixel
pix_valid  in  1  renderer has a pixel for (SaveX, SaveY)
pix_ready  out  1  one-cycle pulse: pixel written, renderer advances
ReadX, ReadY  out  COORD_W each  front-page read coordinate
SaveX, SaveY  out  COORD_W each  back-page write coordinate
SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N  out  1 each  SRAM strobes
fifo_we  out  1  one-cycle push of the current SRAM read data into the FIFO
PauseVGA  out  1  holds vga_controller while a line is prefetched
flip_page  out  1  selects the front page (0: page A displayed)
frame_done  out  1  one-cycle pulse on each page flip

Behaviour:
- Reset (synchronous, active-high) values:
  - state READ; all coordinates 0.
  - Access counter 0; flip_page 0; frame_ready 0; exit_pend 0.
  - All registered pulses 0.
  - Reset asserted mid-access aborts the access; no fifo_we or pix_ready is issued for it.
- Default strobes: all _N outputs high, except as listed per state.
- READ:
  - PauseVGA=1, CE_N=UB_N=LB_N=OE_N=0.
  - The counter runs 0..RD_CYC-1 per pixel.
  - fifo_we=1 only on count RD_CYC-1 with fifo_full=0. At that point the counter goes to 0 and ReadX increments.
  - If fifo_full=1 at count RD_CYC-1, the counter holds and no push occurs.
  - Completing the push of pixel H_RES-1 moves the state to RD2WR.
- RD2WR (1 cycle, bus turnaround):
  - All strobes high; PauseVGA=0.
  - ReadX<=0; ReadY<=ReadY+1, wrapping to 0 when it would reach V_RES.
  - Next state WRITE.
- WRITE:
  - PauseVGA=0.
  - A pixel access starts on pix_valid=1 with the counter at 0 and frame_ready=0.
  - During the access, CE_N=UB_N=LB_N=0 and OE_N=1. WE_N=0 on counts 0..WR_CYC-2 and WE_N=1 on count WR_CYC-1 (data hold).
  - pix_ready=1 on count WR_CYC-1. SaveX then increments; at H_RES-1 it wraps to 0 and SaveY increments.
  - Completing pixel (H_RES-1, V_RES-1) sets frame_ready=1 and leaves SaveX/SaveY at their final values. No further accesses start until the flip.
  - pix_valid dropping mid-access is ignored; an access always completes.
- Flip:
  - Condition (checked in any state): frame_ready=1, VGA_BLANK_N=0 and DrawY>=V_RES.
  - Next cycle: flip_page toggles, SaveX=SaveY=0, frame_ready=0, frame_done=1 for one cycle.
- WRITE exit:
  - DrawX==H_RES-1 requests exit.
  - If no access is in progress, the next state is WR2RD.
  - Otherwise exit_pend is set, and the state moves to WR2RD on the cycle after the access completes.
- WR2RD (1 cycle): all strobes high; PauseVGA=1; exit_pend cleared; next state READ.
- Simultaneous events:
  - Flip condition on the cycle pixel (H_RES-1, V_RES-1) completes: the flip waits one cycle (frame_ready must already be registered).
  - Exit request on the final write cycle: the access completes, then the state moves to WR2RD.
- Width rule: all coordinate arithmetic is COORD_W bits; compares use H_RES-1 and V_RES-1 truncated to COORD_W.

Decomposition:
- Package fb_pkg holds:
  - enum fb_state_t {READ, RD2WR, WRITE, WR2RD};
  - default resolution and cycle constants.
- One sub-module, fb_access_timer, is natural: a counter with start, hold and last outputs, parameterised by cycle count. It is instantiated once for reads and once for writes.

Test Plan:
- Reset asserted for 2 cycles, then released → state READ, PauseVGA=1, coordinates 0, flip_page=0, no fifo_we for RD_CYC-1 cycles.
- H_RES=8, RD_CYC=3, fifo_full=0 → exactly 8 fifo_we pulses, 3 cycles apart; then RD2WR; ReadY=1, ReadX=0.
- fifo_full high for 5 cycles at pixel 3 → fifo_we suppressed; ReadX holds at 3; the push occurs on the first cycle after fifo_full drops.
- pix_valid=1 continuously, WR_CYC=3 → WE_N low 2 cycles, high 1 cycle per pixel; pix_ready every 3 cycles; SaveX wraps 7→0 with SaveY+1.
- DrawX=H_RES-1 at write count 1 → the access completes with pix_ready, then WR2RD; no partial write.
- Full 8x4 frame rendered, then DrawY=V_RES with VGA_BLANK_N=0 → flip_page toggles once, frame_done pulses 1 cycle, SaveX=SaveY=0. Reset asserted mid-write → strobes high next cycle, no pix_ready.
